// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: pipeline (P) has fixed priority, debug port (D) is aged
// so it is forced through after MAX_WAIT consecutive denied cycles.
//
// state   | meaning
// --------+--------------------------------------------------
// RD_NONE | no read return expected this cycle
// RD_P    | mem_rdata this cycle belongs to the pipeline read
// RD_D    | mem_rdata this cycle belongs to the debug read
module dm_port_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_rw,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_stall,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_P    = 2'd1,
    RD_D    = 2'd2
  } rd_state_t;

  rd_state_t         state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [DATA_W-1:0] p_hold;
  logic [DATA_W-1:0] d_hold;
  logic              force_d;
  logic              gnt_p;
  logic              gnt_d;

  assign force_d = d_req & (wait_cnt == WAIT_MAX);
  assign gnt_p   = p_req & ~force_d;
  assign gnt_d   = d_req & ~gnt_p;

  assign p_stall = p_req & ~gnt_p;
  assign d_gnt   = gnt_d;
  assign mem_en  = gnt_p | gnt_d;

  always_comb begin
    mem_rw    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_p) begin
      mem_rw    = p_rw;
      mem_addr  = p_addr;
      mem_wdata = p_wdata;
    end else if (gnt_d) begin
      mem_rw    = d_rw;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  assign p_rvalid = (state == RD_P);
  assign d_rvalid = (state == RD_D);

  // Returning data is forwarded straight through, then held for later cycles.
  assign p_rdata = p_rvalid ? mem_rdata : p_hold;
  assign d_rdata = d_rvalid ? mem_rdata : d_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RD_NONE;
      wait_cnt <= '0;
      p_hold   <= '0;
      d_hold   <= '0;
    end else begin
      if (d_req && !gnt_d) begin
        if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end

      if (state == RD_P) p_hold <= mem_rdata;
      if (state == RD_D) d_hold <= mem_rdata;

      if (gnt_p && !p_rw)      state <= RD_P;
      else if (gnt_d && !d_rw) state <= RD_D;
      else                     state <= RD_NONE;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Randomized bench for dm_port_arbiter: a memory model answers the DUT, and a
// transaction-level reference (grant rule, denied streak, shadow memory) predicts outputs.
module tb_dm_port_arbiter;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 16;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              p_req, p_rw, d_req, d_rw;
  logic [ADDR_W-1:0] p_addr, d_addr;
  logic [DATA_W-1:0] p_wdata, d_wdata;
  logic              p_stall, p_rvalid, d_gnt, d_rvalid;
  logic [DATA_W-1:0] p_rdata, d_rdata;
  logic              mem_en, mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  dm_port_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT), .WAIT_W(3)
  ) dut (
    .clk(clk), .reset(reset),
    .p_req(p_req), .p_rw(p_rw), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_stall(p_stall), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Physical memory driven by the DUT's memory port.
  logic [DATA_W-1:0] mem_arr [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_rw) mem_arr[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr[7:0]];
    end
  end

  // Reference model state.
  logic [DATA_W-1:0] ref_mem [256];
  int                streak;
  int                pend;       // 0 none, 1 read owed to P, 2 read owed to D
  logic [DATA_W-1:0] pend_data;
  logic [DATA_W-1:0] exp_p_hold, exp_d_hold;

  // Values sampled in the most recent cycle, for directed spot checks.
  logic              s_p_rvalid, s_d_rvalid, s_d_gnt, s_p_stall;
  logic [DATA_W-1:0] s_p_rdata, s_d_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic r,
                     input logic pq, input logic prw, input logic [15:0] pa, input logic [15:0] pw,
                     input logic dq, input logic drw, input logic [15:0] da, input logic [15:0] dw);
    logic fd, gp, gd, e_rw;
    logic [15:0] e_addr, e_wdata;
    @(negedge clk);
    reset = r;
    p_req = pq; p_rw = prw; p_addr = pa; p_wdata = pw;
    d_req = dq; d_rw = drw; d_addr = da; d_wdata = dw;
    #1;
    fd = dq && (streak == MAX_WAIT);
    gp = pq && !fd;
    gd = dq && !gp;
    e_rw = 1'b0; e_addr = '0; e_wdata = '0;
    if (gp)      begin e_rw = prw; e_addr = pa; e_wdata = pw; end
    else if (gd) begin e_rw = drw; e_addr = da; e_wdata = dw; end
    chk("p_stall",   p_stall,   pq && !gp);
    chk("d_gnt",     d_gnt,     gd);
    chk("mem_en",    mem_en,    gp || gd);
    chk("mem_rw",    mem_rw,    e_rw);
    chk("mem_addr",  mem_addr,  e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("p_rvalid",  p_rvalid,  pend == 1);
    chk("d_rvalid",  d_rvalid,  pend == 2);
    chk("p_rdata",   p_rdata,   (pend == 1) ? pend_data : exp_p_hold);
    chk("d_rdata",   d_rdata,   (pend == 2) ? pend_data : exp_d_hold);
    s_p_rvalid = p_rvalid; s_d_rvalid = d_rvalid; s_d_gnt = d_gnt;
    s_p_stall = p_stall; s_p_rdata = p_rdata; s_d_rdata = d_rdata;
    @(posedge clk);
    // Memory sees the access regardless of reset; arbiter state does not.
    if ((gp || gd) && e_rw) ref_mem[e_addr[7:0]] = e_wdata;
    if (r) begin
      streak = 0; pend = 0; exp_p_hold = '0; exp_d_hold = '0;
    end else begin
      if (pend == 1) exp_p_hold = pend_data;
      if (pend == 2) exp_d_hold = pend_data;
      pend = 0;
      if ((gp || gd) && !e_rw) begin
        pend      = gp ? 1 : 2;
        pend_data = ref_mem[e_addr[7:0]];
      end
      if (dq && !gd) streak = (streak < MAX_WAIT) ? streak + 1 : MAX_WAIT;
      else           streak = 0;
    end
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = 16'($urandom);
      ref_mem[i] = mem_arr[i];
    end
    mem_arr[8'h03] = 16'hFFFF; ref_mem[8'h03] = 16'hFFFF;
    mem_arr[8'h10] = 16'hABCD; ref_mem[8'h10] = 16'hABCD;
    mem_arr[8'h20] = 16'h5555; ref_mem[8'h20] = 16'h5555;

    reset = 1'b1;
    p_req = 0; p_rw = 0; p_addr = 0; p_wdata = 0;
    d_req = 0; d_rw = 0; d_addr = 0; d_wdata = 0;
    repeat (2) @(posedge clk);
    streak = 0; pend = 0; pend_data = '0; exp_p_hold = '0; exp_d_hold = '0;

    // Reset state, then single P read.
    idle();
    chk("rst_p_rvalid", s_p_rvalid, 1'b0);
    chk("rst_p_rdata", s_p_rdata, 16'h0);
    cyc(0, 1, 0, 16'h0003, 16'h0, 0, 0, 16'h0, 16'h0);
    idle();
    chk("tp1_rvalid", s_p_rvalid, 1'b1);
    chk("tp1_rdata", s_p_rdata, 16'hFFFF);
    chk("tp1_d_rvalid", s_d_rvalid, 1'b0);

    // Write then read back.
    cyc(0, 1, 1, 16'h0003, 16'h1234, 0, 0, 16'h0, 16'h0);
    chk("tp2_stall_w", s_p_stall, 1'b0);
    cyc(0, 1, 0, 16'h0003, 16'h0, 0, 0, 16'h0, 16'h0);
    chk("tp2_norv_w", s_p_rvalid, 1'b0);
    idle();
    chk("tp2_rdata", s_p_rdata, 16'h1234);

    // Continuous contention: D forced through every fifth cycle.
    for (int i = 1; i <= 10; i++) begin
      cyc(0, 1, 0, 16'h0020, 16'h0, 1, 0, 16'h0010, 16'h0);
      chk("tp3_dgnt", s_d_gnt, (i % 5) == 0);
    end
    idle();

    // Independent hold registers.
    cyc(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0010, 16'h0);
    cyc(0, 1, 0, 16'h0020, 16'h0, 0, 0, 16'h0, 16'h0);
    chk("tp4_d_rdata", s_d_rdata, 16'hABCD);
    idle();
    chk("tp4_p_rdata", s_p_rdata, 16'h5555);
    chk("tp4_d_hold", s_d_rdata, 16'hABCD);

    // D drops its request after three denials: aging restarts.
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 16'h0020, 16'h0, 1, 0, 16'h0010, 16'h0);
    cyc(0, 1, 0, 16'h0020, 16'h0, 0, 0, 16'h0, 16'h0);
    for (int j = 1; j <= 5; j++) begin
      cyc(0, 1, 0, 16'h0020, 16'h0, 1, 0, 16'h0010, 16'h0);
      chk("tp5_dgnt", s_d_gnt, j == 5);
    end

    // Reset lands on a granted P read.
    cyc(1, 1, 0, 16'h0020, 16'h0, 0, 0, 16'h0, 16'h0);
    idle();
    chk("tp6_rvalid", s_p_rvalid, 1'b0);
    chk("tp6_p_rdata", s_p_rdata, 16'h0);
    chk("tp6_d_rdata", s_d_rdata, 16'h0);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(63) == 0,
          $urandom_range(9) < 7, 1'($urandom), 16'($urandom_range(15)), 16'($urandom),
          $urandom_range(1) == 1, 1'($urandom), 16'($urandom_range(15)), 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single-port data memory between two requesters.
- Requester P is the pipeline MEM stage. Requester D is the debug/program-loader port.
- Pipeline has fixed priority. An aging counter guarantees D a slot after MAX_WAIT cycles of starvation, during which P is stalled.
- Sits between the EX/MEM pipeline register and the data memory block. Memory is synchronous-read: data appears on mem_rdata the cycle after an enabled read.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 16, address width.
- MAX_WAIT, 4, consecutive cycles D may be denied before it is forcibly granted (range 1..7).
- WAIT_W, 3, width of the aging counter; must hold MAX_WAIT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state on the next rising clk edge.
- p_req  in  1  pipeline requests an access this cycle.
- p_rw  in  1  1 = write, 0 = read.
- p_addr  in  ADDR_W  pipeline address.
- p_wdata  in  DATA_W  pipeline write data.
- p_stall  out  1  pipeline access not accepted this cycle; pipeline must hold its request.
- p_rvalid  out  1  pipeline read data valid on p_rdata.
- p_rdata  out  DATA_W  pipeline read data.
- d_req  in  1  debug port request.
- d_rw  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  debug address.
- d_wdata  in  DATA_W  debug write data.
- d_gnt  out  1  debug access accepted this cycle.
- d_rvalid  out  1  debug read data valid on d_rdata.
- d_rdata  out  DATA_W  debug read data.
- mem_en  out  1  memory enable.
- mem_rw  out  1  memory write (1) / read (0).
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, one-cycle latency.

Behaviour:
- Arbitration is combinational within the cycle:
  - force_d = d_req & (wait_cnt == MAX_WAIT).
  - gnt_p = p_req & ~force_d.
  - gnt_d = d_req & ~gnt_p.
- Outputs driven from the grant:
  - mem_en = gnt_p | gnt_d.
  - mem_rw/mem_addr/mem_wdata are muxed from the granted requester.
  - When idle, mem_rw = 0 and mem_addr/mem_wdata = 0.
- p_stall = p_req & ~gnt_p. d_gnt = gnt_d.
- Aging counter wait_cnt (WAIT_W bits), updated on rising clk edge:
  - d_req & ~gnt_d: increment, saturating at MAX_WAIT.
  - Otherwise (granted or no request): clear to 0.
- Read-return tracker is a registered 2-bit state: NONE, RD_P, RD_D.
  - Next state is RD_P if gnt_p & ~p_rw; RD_D if gnt_d & ~d_rw; else NONE.
  - Writes never produce rvalid.
- Read-return outputs:
  - p_rvalid = (state == RD_P). d_rvalid = (state == RD_D).
  - When rvalid is asserted, the matching rdata output equals mem_rdata that cycle, and the value is captured into that requester's hold register.
  - Otherwise each rdata output shows its hold register.
  - Hold registers are independent; a D read never changes p_rdata.
- Latency:
  - A granted read returns exactly 1 cycle after grant.
  - Back-to-back reads are allowed every cycle; grants may alternate P/D cycle by cycle.
- Reset values:
  - wait_cnt = 0, state = NONE, both hold registers = 0.
  - Hence p_rvalid = d_rvalid = 0 and p_rdata = d_rdata = 0.
  - mem_en, p_stall and d_gnt follow the inputs combinationally. With no requests they are 0.
- Reset mid-operation: a read granted in the cycle reset is sampled produces no rvalid (state forced to NONE) and its data is discarded.
- Simultaneous requests with wait_cnt < MAX_WAIT: P wins and D's counter increments.
- With wait_cnt == MAX_WAIT: D wins for exactly one cycle, P is stalled, and the counter clears.
- D dropping its request: if d_req deasserts while waiting, the counter clears. No memory of prior waiting is kept.

Test Plan:
- Reset, then P read addr 0x0003 with mem model returning 0xFFFF -> mem_en=1, mem_rw=0, mem_addr=0x0003 in grant cycle; next cycle p_rvalid=1, p_rdata=0xFFFF; d_rvalid stays 0.
- P write addr 0x0003 data 0x1234, then P read 0x0003 -> write has no rvalid; read returns 0x1234 one cycle after its grant; p_stall=0 throughout.
- P and D both request continuously, MAX_WAIT=4 -> P granted cycles 1-4, D granted cycle 5 with p_stall=1 for that cycle only, then pattern repeats every 5 cycles.
- D read 0x0010 (memory 0xABCD) alone, then P read 0x0020 (memory 0x5555) -> d_rdata=0xABCD and stays there after the P read; p_rdata=0x5555.
- D waiting with wait_cnt=3, d_req dropped one cycle then reasserted with P active -> counter restarts from 0; D granted only after 4 further denied cycles.
- Assert reset in the cycle a P read is granted -> next cycle p_rvalid=0, p_rdata=0, wait_cnt=0.
